// File: rtl/mul_issue_unit.sv
// Execute-stage wrapper around the unsigned shift-add multiplier core:
// operand magnitudes, core handshake, sign fix-up and result return.
module mul_issue_unit #(
    parameter int XLEN        = 32,
    parameter bit ZERO_BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [XLEN-1:0]   in_a,
    input  logic [XLEN-1:0]   in_b,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_data,
    output logic              busy,
    output logic              mul_valid,
    output logic [XLEN-1:0]   mul_a,
    output logic [XLEN-1:0]   mul_b,
    input  logic              mul_done,
    input  logic [2*XLEN-1:0] mul_c
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_FIX,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t state, state_nx;

    logic [1:0]        op_q;
    logic              neg_q;
    logic              first_q;
    logic              accept;
    logic              zero;
    logic              sa;
    logic              sb;
    logic              done_ok;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   res;

    always_comb begin
        accept  = in_valid & (state == S_IDLE) & ~flush;
        zero    = ZERO_BYPASS & ((in_a == '0) | (in_b == '0));
        sa      = (in_op == 2'b01) | (in_op == 2'b10);
        sb      = (in_op == 2'b01);
        // The core still shows the previous done in the cycle after start.
        done_ok = mul_done & ~first_q;
        prod    = neg_q ? -mul_c : mul_c;
        res     = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (accept) state_nx = zero ? S_DONE : S_LAUNCH;
            S_LAUNCH: state_nx = flush ? S_DRAIN : S_WAIT;
            S_WAIT: begin
                if (flush)        state_nx = S_DRAIN;
                else if (done_ok) state_nx = S_FIX;
            end
            S_FIX:    state_nx = flush ? S_IDLE : S_DONE;
            S_DONE:   if (flush | out_ready) state_nx = S_IDLE;
            S_DRAIN:  if (done_ok) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            op_q     <= 2'b00;
            neg_q    <= 1'b0;
            first_q  <= 1'b0;
            mul_a    <= '0;
            mul_b    <= '0;
            out_data <= '0;
        end else begin
            state   <= state_nx;
            first_q <= (state == S_LAUNCH);
            if (accept) begin
                op_q  <= in_op;
                neg_q <= (sa & in_a[XLEN-1]) ^ (sb & in_b[XLEN-1]);
                if (zero) begin
                    out_data <= '0;
                end else begin
                    mul_a <= (sa & in_a[XLEN-1]) ? -in_a : in_a;
                    mul_b <= (sb & in_b[XLEN-1]) ? -in_b : in_b;
                end
            end
            if ((state == S_FIX) && !flush) out_data <= res;
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign busy      = ~in_ready;
    assign out_valid = (state == S_DONE);
    assign mul_valid = (state == S_LAUNCH);

endmodule

// File: tb/tb_mul_issue_unit.sv
// Bench for mul_issue_unit: behavioural multiplier core plus an
// arithmetic reference for the RV M-extension multiply results.
module tb_mul_issue_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'b00;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        busy;
    logic        mul_valid;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_done;
    logic [63:0] mul_c;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int lat = 3;
    int rise_cyc = 0;
    int nmv = 0;
    logic done_prev = 1'b1;

    logic core_busy;
    logic core_pend;
    int   core_cnt;

    mul_issue_unit #(.XLEN(32), .ZERO_BYPASS(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .mul_valid (mul_valid),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_done  (mul_done),
        .mul_c     (mul_c)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Core: done stays high one cycle after start, product lands a cycle after done rises.
    always @(posedge clk) begin
        if (reset) begin
            mul_done  <= 1'b1;
            core_busy <= 1'b0;
            core_pend <= 1'b0;
            core_cnt  <= 0;
            mul_c     <= '0;
        end else begin
            if (core_pend) begin
                mul_c     <= {32'b0, mul_a} * {32'b0, mul_b};
                core_pend <= 1'b0;
            end
            if (mul_valid) begin
                core_busy <= 1'b1;
                core_cnt  <= lat;
                mul_c     <= {$urandom, $urandom};
            end else if (core_busy) begin
                if (core_cnt == 0) begin
                    mul_done  <= 1'b1;
                    core_busy <= 1'b0;
                    core_pend <= 1'b1;
                end else begin
                    mul_done <= 1'b0;
                    core_cnt <= core_cnt - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mul_done && !done_prev) rise_cyc = cyc;
        done_prev = mul_done;
        if (mul_valid) nmv++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic start(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        int k;
        k = 0;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_op = op;
        in_a = a;
        in_b = b;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic do_req(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold,
                          input bit fl_done);
        logic [31:0] exp, ma, mb;
        bit byp;
        int k, nmv0;
        exp = ref_mul(op, a, b);
        byp = (a == 0) || (b == 0);
        ma = ((op == 2'b01 || op == 2'b10) && a[31]) ? 32'd0 - a : a;
        mb = ((op == 2'b01) && b[31]) ? 32'd0 - b : b;
        nmv0 = nmv;
        start(op, a, b);
        @(negedge clk);
        if (byp) begin
            chk("byp_outv", out_valid, 1);
            chk("byp_mulv", mul_valid, 0);
        end else begin
            chk("launch", mul_valid, 1);
            chk("mul_a", mul_a, ma);
            chk("mul_b", mul_b, mb);
            chk("busy", busy, 1);
            @(negedge clk);
            chk("pulse", mul_valid, 0);
            k = 0;
            while (!out_valid && k < 200) begin
                @(negedge clk);
                k++;
            end
            chk("outv", out_valid, 1);
            chk("latency", cyc - rise_cyc, 2);
        end
        chk("data", out_data, exp);
        if (fl_done) begin
            flush = 1'b1;
            out_ready = 1'b1;
            @(posedge clk);
            #1 flush = 1'b0;
            out_ready = 1'b0;
            @(negedge clk);
            chk("fl_outv", out_valid, 0);
            chk("fl_rdy", in_ready, 1);
        end else begin
            repeat (hold) begin
                @(negedge clk);
                chk("hold_v", out_valid, 1);
                chk("hold_d", out_data, exp);
                chk("hold_rdy", in_ready, 0);
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
            @(negedge clk);
            chk("ret_v", out_valid, 0);
            chk("ret_rdy", in_ready, 1);
        end
        if (byp) chk("byp_nocore", nmv - nmv0, 0);
    endtask

    initial begin
        logic [31:0] corner [5];
        logic [31:0] a, b;
        int k;
        corner[0] = 32'h0;
        corner[1] = 32'h1;
        corner[2] = 32'h8000_0000;
        corner[3] = 32'hFFFF_FFFF;
        corner[4] = 32'h7FFF_FFFF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_outv", out_valid, 0);
        chk("rst_mulv", mul_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_mula", mul_a, 0);
        chk("rst_mulb", mul_b, 0);
        reset = 1'b0;
        @(negedge clk);

        lat = 4;
        do_req(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        do_req(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        do_req(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
        do_req(2'b01, 32'h8000_0000, 32'h8000_0000, 0, 0);
        do_req(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        do_req(2'b10, 32'hFFFF_FFFE, 32'd3, 0, 0);
        do_req(2'b00, 32'hFFFF_FFF9, 32'd3, 2, 0);
        do_req(2'b00, 32'h0, 32'h1234, 2, 0);

        // Flush deep in WAIT: core must drain before the next accept.
        lat = 12;
        start(2'b00, 32'd5, 32'd5);
        repeat (6) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        k = 0;
        while (k < 100) begin
            @(negedge clk);
            if (in_ready) break;
            chk("drain_outv", out_valid, 0);
            k++;
        end
        chk("drain_rdy", in_ready, 1);
        chk("drain_lat", cyc - rise_cyc, 1);
        lat = 3;
        do_req(2'b00, 32'd6, 32'd7, 10, 0);

        do_req(2'b01, 32'hFFFF_FFFD, 32'd9, 0, 1);

        // Reset in the middle of WAIT.
        lat = 20;
        start(2'b11, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_rdy", in_ready, 1);
        chk("mrst_outv", out_valid, 0);
        chk("mrst_mulv", mul_valid, 0);
        chk("mrst_data", out_data, 0);
        chk("mrst_mula", mul_a, 0);
        chk("mrst_mulb", mul_b, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)]
                                            : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)]
                                            : $urandom;
            lat = $urandom_range(1, 10);
            do_req(2'($urandom_range(0, 3)), a, b, $urandom_range(0, 3),
                   ($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
